// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, ALU and a
// multi-cycle signed restoring divider, all sharing one 32-bit bus.
module datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] R_rd,
  input  logic [15:0] R_wrt,
  input  logic        HI_out,
  input  logic        LO_out,
  input  logic        Zhi_out,
  input  logic        Zlo_out,
  input  logic        PC_out,
  input  logic        MDR_out,
  input  logic        MAR_out,
  input  logic        In_out,
  input  logic        C_out,
  input  logic        MAR_rd,
  input  logic        Zhi_rd,
  input  logic        Zlo_rd,
  input  logic        PC_rd,
  input  logic        MDR_rd,
  input  logic        IR_rd,
  input  logic        Y_rd,
  input  logic        HI_rd,
  input  logic        LO_rd,
  input  logic        IncPC,
  input  logic        Read,
  input  logic [31:0] Mdatain,
  input  logic [4:0]  op_sel,
  input  logic        reset_div,
  output logic        calc_finished,
  output logic [31:0] r2_view,
  output logic [31:0] r6_view,
  output logic [31:0] Y_view,
  output logic [31:0] Zhi_view,
  output logic [31:0] Zlo_view,
  output logic [31:0] MDR_view,
  output logic [31:0] PC_view,
  output logic [31:0] BusMuxOut,
  output logic [31:0] Data_view
);

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_CAPTURE = 2'd1,
    DIV_RUN     = 2'd2,
    DIV_DONE    = 2'd3
  } div_state_t;

  logic [31:0] r_file [16];
  logic [31:0] hi_reg, lo_reg, zhi_reg, zlo_reg;
  logic [31:0] pc_reg, mdr_reg, mar_reg, y_reg;
  // Only the immediate field of IR is ever consumed (C drive).
  logic [18:0] ir_reg;
  logic [31:0] c_sext;

  logic [31:0] alu_hi, alu_lo;
  logic [63:0] mul_a, mul_b, mul_res;
  logic [63:0] y_dbl, ror_full, rol_full;
  logic [4:0]  shamt;

  div_state_t  div_state_reg, div_state_next;
  logic [4:0]  div_count_reg;
  logic [31:0] div_rem_reg, div_quo_reg, div_dsr_reg, div_dividend_reg;
  logic        div_neg_q_reg, div_neg_r_reg, div_zero_reg;
  logic [32:0] div_shifted;
  logic [33:0] div_trial;
  logic        div_fits;
  logic [31:0] div_quotient, div_remainder;
  logic [31:0] y_mag, bus_mag;

  // General register file
  for (genvar gi = 0; gi < 16; gi++) begin : g_gpr
    logic [31:0] q_reg;
    always_ff @(posedge clk or posedge clr) begin
      if (clr)
        q_reg <= '0;
      else if (R_rd[gi])
        q_reg <= BusMuxOut;
    end
    assign r_file[gi] = q_reg;
  end

  assign Data_view = Read ? Mdatain : BusMuxOut;
  assign c_sext    = {{13{ir_reg[18]}}, ir_reg};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      zhi_reg <= '0;
      zlo_reg <= '0;
      pc_reg  <= '0;
      mdr_reg <= '0;
      mar_reg <= '0;
      y_reg   <= '0;
      ir_reg  <= '0;
    end else begin
      if (HI_rd)  hi_reg  <= BusMuxOut;
      if (LO_rd)  lo_reg  <= BusMuxOut;
      if (Zhi_rd) zhi_reg <= alu_hi;
      if (Zlo_rd) zlo_reg <= alu_lo;
      if (MDR_rd) mdr_reg <= Data_view;
      if (MAR_rd) mar_reg <= BusMuxOut;
      if (Y_rd)   y_reg   <= BusMuxOut;
      if (IR_rd)  ir_reg  <= BusMuxOut[18:0];
      if (PC_rd)
        pc_reg <= BusMuxOut;
      else if (IncPC)
        pc_reg <= pc_reg + 32'd1;
    end
  end

  // Bus mux: later assignments override earlier ones, so R0 ends up highest priority.
  always_comb begin
    BusMuxOut = '0;
    if (C_out)   BusMuxOut = c_sext;
    if (In_out)  BusMuxOut = '0;
    if (MAR_out) BusMuxOut = mar_reg;
    if (MDR_out) BusMuxOut = mdr_reg;
    if (PC_out)  BusMuxOut = pc_reg;
    if (Zlo_out) BusMuxOut = zlo_reg;
    if (Zhi_out) BusMuxOut = zhi_reg;
    if (LO_out)  BusMuxOut = lo_reg;
    if (HI_out)  BusMuxOut = hi_reg;
    for (int i = 15; i >= 0; i--) begin
      if (R_wrt[i]) BusMuxOut = r_file[i];
    end
  end

  assign mul_a    = {{32{y_reg[31]}}, y_reg};
  assign mul_b    = {{32{BusMuxOut[31]}}, BusMuxOut};
  assign mul_res  = mul_a * mul_b;
  assign shamt    = BusMuxOut[4:0];
  assign y_dbl    = {y_reg, y_reg};
  assign ror_full = y_dbl >> shamt;
  assign rol_full = y_dbl << shamt;

  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    case (op_sel)
      5'b00011: alu_lo = y_reg + BusMuxOut;
      5'b00100: alu_lo = y_reg - BusMuxOut;
      5'b00101: alu_lo = y_reg >> shamt;
      5'b00110: alu_lo = y_reg << shamt;
      5'b00111: alu_lo = ror_full[31:0];
      5'b01000: alu_lo = rol_full[63:32];
      5'b01001: alu_lo = y_reg & BusMuxOut;
      5'b01010: alu_lo = y_reg | BusMuxOut;
      5'b01110: {alu_hi, alu_lo} = mul_res;
      5'b01111: begin
        alu_hi = div_remainder;
        alu_lo = div_quotient;
      end
      5'b10000: alu_lo = -BusMuxOut;
      5'b10001: alu_lo = ~BusMuxOut;
      default: begin
        alu_hi = '0;
        alu_lo = '0;
      end
    endcase
  end

  // Divider state: reset_div low forces CAPTURE asynchronously so short pulses are never missed.
  always_ff @(posedge clk or posedge clr or negedge reset_div) begin
    if (clr)
      div_state_reg <= DIV_IDLE;
    else if (!reset_div)
      div_state_reg <= DIV_CAPTURE;
    else
      div_state_reg <= div_state_next;
  end

  always_comb begin
    div_state_next = div_state_reg;
    case (div_state_reg)
      DIV_IDLE:    div_state_next = DIV_IDLE;
      DIV_CAPTURE: div_state_next = DIV_RUN;
      DIV_RUN:     div_state_next = (div_count_reg == 5'd31) ? DIV_DONE : DIV_RUN;
      DIV_DONE:    div_state_next = DIV_DONE;
      default:     div_state_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    calc_finished = (div_state_reg == DIV_DONE);
    if (div_zero_reg) begin
      div_quotient  = 32'hFFFF_FFFF;
      div_remainder = div_dividend_reg;
    end else begin
      div_quotient  = div_neg_q_reg ? -div_quo_reg : div_quo_reg;
      div_remainder = div_neg_r_reg ? -div_rem_reg : div_rem_reg;
    end
  end

  assign y_mag   = y_reg[31] ? -y_reg : y_reg;
  assign bus_mag = BusMuxOut[31] ? -BusMuxOut : BusMuxOut;

  // Magnitude restoring step: the dividend shifts out of the quotient register MSB first.
  assign div_shifted = {div_rem_reg, div_quo_reg[31]};
  assign div_trial   = {1'b0, div_shifted} - {2'b00, div_dsr_reg};
  assign div_fits    = ~div_trial[33];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div_count_reg    <= '0;
      div_rem_reg      <= '0;
      div_quo_reg      <= '0;
      div_dsr_reg      <= '0;
      div_dividend_reg <= '0;
      div_neg_q_reg    <= 1'b0;
      div_neg_r_reg    <= 1'b0;
      div_zero_reg     <= 1'b0;
    end else begin
      case (div_state_reg)
        DIV_CAPTURE: begin
          div_count_reg    <= '0;
          div_rem_reg      <= '0;
          div_quo_reg      <= y_mag;
          div_dsr_reg      <= bus_mag;
          div_dividend_reg <= y_reg;
          div_neg_q_reg    <= y_reg[31] ^ BusMuxOut[31];
          div_neg_r_reg    <= y_reg[31];
          div_zero_reg     <= (BusMuxOut == 32'd0);
        end
        DIV_RUN: begin
          div_count_reg <= div_count_reg + 5'd1;
          div_rem_reg   <= div_fits ? div_trial[31:0] : div_shifted[31:0];
          div_quo_reg   <= {div_quo_reg[30:0], div_fits};
        end
        default: begin
          div_count_reg <= div_count_reg;
        end
      endcase
    end
  end

  assign r2_view  = r_file[2];
  assign r6_view  = r_file[6];
  assign Y_view   = y_reg;
  assign Zhi_view = zhi_reg;
  assign Zlo_view = zlo_reg;
  assign MDR_view = mdr_reg;
  assign PC_view  = pc_reg;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed register/bus sequences, an ALU vector table,
// randomized ALU and divider runs checked against an arithmetic model.
module tb_datapath;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] R_rd, R_wrt;
  logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
  logic        MAR_rd, Zhi_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, HI_rd, LO_rd;
  logic        IncPC, Read;
  logic [31:0] Mdatain;
  logic [4:0]  op_sel;
  logic        reset_div = 1'b1;
  logic        calc_finished;
  logic [31:0] r2_view, r6_view, Y_view, Zhi_view, Zlo_view, MDR_view, PC_view;
  logic [31:0] BusMuxOut, Data_view;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .clr(clr), .R_rd(R_rd), .R_wrt(R_wrt),
    .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PC_out(PC_out), .MDR_out(MDR_out), .MAR_out(MAR_out), .In_out(In_out), .C_out(C_out),
    .MAR_rd(MAR_rd), .Zhi_rd(Zhi_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd),
    .IR_rd(IR_rd), .Y_rd(Y_rd), .HI_rd(HI_rd), .LO_rd(LO_rd),
    .IncPC(IncPC), .Read(Read), .Mdatain(Mdatain), .op_sel(op_sel),
    .reset_div(reset_div), .calc_finished(calc_finished),
    .r2_view(r2_view), .r6_view(r6_view), .Y_view(Y_view), .Zhi_view(Zhi_view),
    .Zlo_view(Zlo_view), .MDR_view(MDR_view), .PC_view(PC_view),
    .BusMuxOut(BusMuxOut), .Data_view(Data_view)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic idle();
    R_rd = '0; R_wrt = '0;
    HI_out = 0; LO_out = 0; Zhi_out = 0; Zlo_out = 0; PC_out = 0;
    MDR_out = 0; MAR_out = 0; In_out = 0; C_out = 0;
    MAR_rd = 0; Zhi_rd = 0; Zlo_rd = 0; PC_rd = 0; MDR_rd = 0;
    IR_rd = 0; Y_rd = 0; HI_rd = 0; LO_rd = 0;
    IncPC = 0; Read = 0; Mdatain = '0; op_sel = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle();
    Mdatain = v; Read = 1; MDR_rd = 1;
    tick();
    idle();
  endtask

  task automatic load_y(input logic [31:0] v);
    load_mdr(v);
    MDR_out = 1; Y_rd = 1;
    tick();
    idle();
  endtask

  task automatic alu_apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res);
    load_y(a);
    load_mdr(b);
    MDR_out = 1; op_sel = op; Zhi_rd = 1; Zlo_rd = 1;
    tick();
    idle();
    res = {Zhi_view, Zlo_view};
  endtask

  // Caller has Y loaded and the divisor on the bus; returns {remainder, quotient}.
  task automatic div_core(input string name, output logic [63:0] res);
    int cycles;
    op_sel = 5'b01111;
    reset_div = 0;
    #1;
    check({name, " hold"}, {63'd0, calc_finished}, 64'd0);
    #4;
    reset_div = 1;
    cycles = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (calc_finished) begin
        cycles = n;
        break;
      end
    end
    check({name, " latency"}, 64'(cycles), 64'd33);
    Zhi_rd = 1; Zlo_rd = 1;
    tick();
    idle();
    res = {Zhi_view, Zlo_view};
  endtask

  task automatic div_run(input string name, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res);
    load_y(a);
    load_mdr(b);
    MDR_out = 1;
    div_core(name, res);
  endtask

  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    longint p;
    int sh;
    sh = int'(b[4:0]);
    r = a;
    case (op)
      5'd3:  return {32'd0, a + b};
      5'd4:  return {32'd0, a - b};
      5'd5:  return {32'd0, a >> sh};
      5'd6:  return {32'd0, a << sh};
      5'd7:  begin repeat (sh) r = {r[0], r[31:1]}; return {32'd0, r}; end
      5'd8:  begin repeat (sh) r = {r[30:0], r[31]}; return {32'd0, r}; end
      5'd9:  return {32'd0, a & b};
      5'd10: return {32'd0, a | b};
      5'd14: begin p = longint'($signed(a)) * longint'($signed(b)); return 64'(p); end
      5'd16: return {32'd0, 32'd0 - b};
      5'd17: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    x = longint'($signed(a));
    y = longint'($signed(b));
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] res;
    logic [4:0]  op;
    logic [31:0] a, b;
    int          t;

    vecs[0]  = '{5'b00011, 32'd5,          32'd7,          64'd12};
    vecs[1]  = '{5'b00100, 32'd5,          32'd7,          64'h0000_0000_FFFF_FFFE};
    vecs[2]  = '{5'b01110, 32'hFFFF_FFFE,  32'd3,          64'hFFFF_FFFF_FFFF_FFFA};
    vecs[3]  = '{5'b01110, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
    vecs[4]  = '{5'b00101, 32'h8000_0000,  32'd4,          64'h0000_0000_0800_0000};
    vecs[5]  = '{5'b00110, 32'h0000_0003,  32'd31,         64'h0000_0000_8000_0000};
    vecs[6]  = '{5'b00111, 32'h0000_0001,  32'd1,          64'h0000_0000_8000_0000};
    vecs[7]  = '{5'b01000, 32'h8000_0001,  32'd4,          64'h0000_0000_0000_0018};
    vecs[8]  = '{5'b00111, 32'hDEAD_BEEF,  32'h0000_0020,  64'h0000_0000_DEAD_BEEF};
    vecs[9]  = '{5'b01001, 32'hF0F0_F0F0,  32'hFF00_FF00,  64'h0000_0000_F000_F000};
    vecs[10] = '{5'b01010, 32'hF0F0_F0F0,  32'h0F0F_0000,  64'h0000_0000_FFFF_F0F0};
    vecs[11] = '{5'b10000, 32'h1234_5678,  32'd1,          64'h0000_0000_FFFF_FFFF};
    vecs[12] = '{5'b10001, 32'h0000_0000,  32'h1234_5678,  64'h0000_0000_EDCB_A987};
    vecs[13] = '{5'b00000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd0};

    idle();
    #2 clr = 1;
    #1;
    check("reset r2", {32'd0, r2_view}, 64'd0);
    check("reset pc", {32'd0, PC_view}, 64'd0);
    check("reset zlo/zhi", {Zhi_view, Zlo_view}, 64'd0);
    check("reset y/mdr", {Y_view, MDR_view}, 64'd0);
    check("reset calc_finished", {63'd0, calc_finished}, 64'd0);
    check("reset bus idle", {32'd0, BusMuxOut}, 64'd0);
    @(posedge clk);
    #1 clr = 0;

    // Memory read into MDR, then MDR to R2
    idle();
    Mdatain = 32'd97; Read = 1; MDR_rd = 1;
    #1;
    check("data_view mem", {32'd0, Data_view}, 64'd97);
    tick();
    check("mdr load", {32'd0, MDR_view}, 64'd97);
    idle();
    MDR_out = 1; R_rd[2] = 1;
    #1;
    check("data_view bus", {32'd0, Data_view}, 64'd97);
    tick();
    idle();
    check("r2 load", {32'd0, r2_view}, 64'd97);

    load_mdr(32'd30);
    MDR_out = 1; R_rd[6] = 1;
    tick();
    idle();
    check("r6 load", {32'd0, r6_view}, 64'd30);

    // PC load, increment, and load-beats-increment
    load_mdr(32'd7);
    MDR_out = 1; PC_rd = 1;
    tick();
    idle();
    check("pc load", {32'd0, PC_view}, 64'd7);
    IncPC = 1;
    tick();
    idle();
    check("pc inc", {32'd0, PC_view}, 64'd8);
    MDR_out = 1; PC_rd = 1; IncPC = 1;
    tick();
    idle();
    check("pc load wins", {32'd0, PC_view}, 64'd7);

    // Bus priority and sources
    R_wrt = 16'h0044; HI_out = 1;
    #1;
    check("bus prio r2", {32'd0, BusMuxOut}, 64'd97);
    idle();
    PC_out = 1; MDR_out = 1;
    #1;
    check("bus prio pc", {32'd0, BusMuxOut}, 64'd7);
    idle();
    load_mdr(32'hFFF4_0005);
    MDR_out = 1; IR_rd = 1; MAR_rd = 1;
    tick();
    idle();
    C_out = 1;
    #1;
    check("bus C sext", {32'd0, BusMuxOut}, 64'h0000_0000_FFFC_0005);
    idle();
    MAR_out = 1;
    #1;
    check("bus MAR", {32'd0, BusMuxOut}, 64'h0000_0000_FFF4_0005);
    idle();
    In_out = 1;
    #1;
    check("bus In", {32'd0, BusMuxOut}, 64'd0);
    idle();

    // Division from registers: R2 / R6
    R_wrt[2] = 1; Y_rd = 1;
    tick();
    idle();
    R_wrt[6] = 1;
    div_core("div 97/30", res);
    check("div 97/30 result", res, {32'd7, 32'd3});
    Zlo_out = 1; LO_rd = 1;
    tick();
    idle();
    Zhi_out = 1; HI_rd = 1;
    tick();
    idle();
    LO_out = 1;
    #1;
    check("LO via bus", {32'd0, BusMuxOut}, 64'd3);
    idle();
    HI_out = 1;
    #1;
    check("HI via bus", {32'd0, BusMuxOut}, 64'd7);
    idle();

    div_run("div -97/30", 32'hFFFF_FF9F, 32'd30, res);
    check("div -97/30 result", res, {32'hFFFF_FFF9, 32'hFFFF_FFFD});
    div_run("div -97/0", 32'hFFFF_FF9F, 32'd0, res);
    check("div -97/0 result", res, {32'hFFFF_FF9F, 32'hFFFF_FFFF});
    div_run("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, res);
    check("div min/-1 result", res, div_model(32'h8000_0000, 32'hFFFF_FFFF));

    // ALU vector table
    for (int i = 0; i < 14; i++) begin
      alu_apply(vecs[i].op, vecs[i].a, vecs[i].b, res);
      check($sformatf("vec%0d op=%0d a=%h b=%h", i, vecs[i].op, vecs[i].a, vecs[i].b),
            res, vecs[i].exp);
    end

    // Randomized ALU against the model
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd15) op = 5'd3;
      a = $urandom;
      b = $urandom;
      alu_apply(op, a, b, res);
      check($sformatf("rand alu op=%0d a=%h b=%h", op, a, b), res, alu_model(op, a, b));
    end

    // Randomized division against the model
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      if (i % 2 == 0) begin
        t = int'($urandom_range(0, 200)) - 100;
        b = t;
      end else begin
        b = $urandom;
      end
      div_run($sformatf("rand div %h/%h", a, b), a, b, res);
      check($sformatf("rand div %h/%h result", a, b), res, div_model(a, b));
    end

    // clr in the middle of a division, then a fresh division
    load_y(32'd97);
    load_mdr(32'd30);
    MDR_out = 1; op_sel = 5'b01111;
    reset_div = 0;
    #5 reset_div = 1;
    repeat (10) tick();
    #2 clr = 1;
    #1;
    check("clr mid-div calc_finished", {63'd0, calc_finished}, 64'd0);
    check("clr mid-div y/mdr", {Y_view, MDR_view}, 64'd0);
    check("clr mid-div zhi/zlo", {Zhi_view, Zlo_view}, 64'd0);
    check("clr mid-div r2/r6", {r2_view, r6_view}, 64'd0);
    check("clr mid-div pc", {32'd0, PC_view}, 64'd0);
    #2 clr = 0;
    idle();
    tick();
    div_run("div after clr", 32'd97, 32'd30, res);
    check("div after clr result", res, {32'd7, 32'd3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
